// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store bus initiator (clk, rst, flush, EX/MEM op/addr/data/wb triple in; bus req/we/addr/be/wdata out, rdata/ack in; stallreq, wb triple, address exceptions, bus_err out)
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [7:0] TO = TIMEOUT_CYCLES[7:0];
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, next;
  logic [7:0] op, wdog;
  logic [1:0] off;
  logic drop, aborted;
  logic [31:0] ld;
  logic is_ld, is_st, is_b, is_h, is_w, mis, go, ack_hit, tmo, kill;
  logic [3:0] be_n;
  logic [31:0] wdata_n, ext;
  logic [7:0] rb;
  logic [15:0] rh;
  assign is_ld = mem_aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  assign is_st = mem_aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  assign is_b = mem_aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  assign is_h = mem_aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  assign is_w = mem_aluop inside {EXE_LW_OP, EXE_SW_OP};
  assign mis = (is_h & mem_mem_addr[0]) | (is_w & |mem_mem_addr[1:0]);
  assign go = state == IDLE && (is_ld || is_st) && !mis && !flush;
  assign ack_hit = state == BUS && bus_ack;
  // ack wins over a timeout landing in the same cycle
  assign tmo = state == BUS && !bus_ack && wdog + 8'd1 == TO;
  // a flush arriving in the ack cycle discards the result just like an earlier one
  assign kill = drop | flush;
  assign be_n = is_w ? 4'b1111 : is_h ? (mem_mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << mem_mem_addr[1:0];
  assign wdata_n = is_b ? {4{mem_reg2[7:0]}} : is_h ? {2{mem_reg2[15:0]}} : mem_reg2;
  assign rb = bus_rdata[{off, 3'b000} +: 8];
  assign rh = bus_rdata[{off[1], 4'b0000} +: 16];
  assign ext = op == EXE_LB_OP  ? {{24{rb[7]}}, rb} :
               op == EXE_LBU_OP ? {24'd0, rb} :
               op == EXE_LH_OP  ? {{16{rh[15]}}, rh} :
               op == EXE_LHU_OP ? {16'd0, rh} : bus_rdata;
  always_comb begin
    next = state;
    if (state == IDLE && go) next = BUS;
    if (ack_hit) next = kill ? IDLE : DONE;
    if (tmo) next = DONE;
    if (state == DONE) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      bus_err <= 1'b0;
      wdog <= '0;
      drop <= 1'b0;
      aborted <= 1'b0;
      op <= '0;
      off <= '0;
      ld <= '0;
    end else begin
      state <= next;
      bus_err <= tmo;
      if (go) begin
        bus_req <= 1'b1;
        bus_we <= is_st;
        bus_addr <= {mem_mem_addr[31:2], 2'b00};
        bus_be <= be_n;
        bus_wdata <= is_st ? wdata_n : '0;
        wdog <= '0;
        drop <= 1'b0;
        aborted <= 1'b0;
        op <= mem_aluop;
        off <= mem_mem_addr[1:0];
      end
      if (state == BUS) begin
        drop <= kill;
        wdog <= wdog + 8'd1;
      end
      if (ack_hit) begin
        bus_req <= 1'b0;
        ld <= ext;
      end
      if (tmo) begin
        bus_req <= 1'b0;
        aborted <= 1'b1;
      end
      if (state != IDLE && next == IDLE) begin
        bus_we <= 1'b0;
        bus_addr <= '0;
        bus_be <= '0;
        bus_wdata <= '0;
        drop <= 1'b0;
      end
    end
  end
  always_comb begin
    stallreq = state == BUS || go;
    excp_adel = state == IDLE && is_ld && mis;
    excp_ades = state == IDLE && is_st && mis;
    bad_vaddr = (excp_adel || excp_ades) ? mem_mem_addr : '0;
    wb_wd = mem_wd;
    wb_wdata = (state == DONE && !bus_we) ? ld : mem_wdata;
    wb_wreg = state == IDLE ? mem_wreg && !is_ld && !is_st && !flush :
              state == DONE ? mem_wreg && !bus_we && !aborted && !flush : 1'b0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit (vector table + scoreboard + corner sequences)
module tb_mem_access_unit;
  localparam logic [7:0] LB  = 8'b11100000;
  localparam logic [7:0] LH  = 8'b11100001;
  localparam logic [7:0] LW  = 8'b11100011;
  localparam logic [7:0] LBU = 8'b11100100;
  localparam logic [7:0] LHU = 8'b11100101;
  localparam logic [7:0] SB  = 8'b11101000;
  localparam logic [7:0] SH  = 8'b11101001;
  localparam logic [7:0] SW  = 8'b11101011;
  localparam logic [7:0] NOP = 8'b00100101;
  logic clk = 0, rst = 1, flush = 0, mem_wreg = 0, bus_ack = 0;
  logic [7:0] mem_aluop = NOP;
  logic [31:0] mem_mem_addr = 0, mem_reg2 = 0, mem_wdata = 0, bus_rdata = 0;
  logic [4:0] mem_wd = 0;
  logic bus_req, bus_we, stallreq, wb_wreg, excp_adel, excp_ades, bus_err;
  logic [31:0] bus_addr, bus_wdata, wb_wdata, bad_vaddr;
  logic [3:0] bus_be;
  logic [4:0] wb_wd;
  int total = 0, bad = 0;
  typedef struct {
    logic [7:0] op; logic [31:0] addr, reg2, rdata; int waits;
    logic we; logic [3:0] be; logic [31:0] baddr, bwdata; logic wreg; logic [31:0] wbdata;
  } vec_t;
  typedef struct { logic wreg; logic [31:0] wdata; } exp_t;
  exp_t q[$];
  vec_t vecs[$];
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stallreq(stallreq), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .excp_adel(excp_adel), .excp_ades(excp_ades), .bad_vaddr(bad_vaddr), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
    @(posedge clk); #1;
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    q.push_back('{v.wreg, v.wbdata});
    drive(v.op, v.addr, v.reg2);
    mem_wd = 5'd9; mem_wreg = 1; mem_wdata = 32'h0; bus_rdata = v.rdata; bus_ack = 0;
    @(negedge clk) chk("issue_stall", {bus_req, stallreq}, 2'b01);
    for (int i = 0; i <= v.waits; i++) begin
      @(posedge clk); #1 bus_ack = (i == v.waits);
      @(negedge clk) chk("bus_cycle", {bus_req, bus_we, bus_be, bus_addr, bus_wdata, stallreq},
                         {1'b1, v.we, v.be, v.baddr, v.bwdata, 1'b1});
    end
    @(posedge clk); #1 bus_ack = 0;
    @(negedge clk);
    chk("done_stall_req", {stallreq, bus_req}, 2'b00);
    chk("done_wd", wb_wd, 5'd9);
    if (q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = q.pop_front();
      chk("done_wreg", wb_wreg, e.wreg);
      if (e.wreg) chk("done_wdata", wb_wdata, e.wdata);
    end
    drive(NOP, 0, 0);
    @(negedge clk) chk("back_idle", {stallreq, bus_req}, 2'b00);
  endtask
  initial begin
    int n;
    vecs.push_back('{LB,  32'h103, 0, 32'h80FF1234, 0, 0, 4'b1000, 32'h100, 0, 1, 32'hFFFFFF80});
    vecs.push_back('{LBU, 32'h103, 0, 32'h80FF1234, 0, 0, 4'b1000, 32'h100, 0, 1, 32'h00000080});
    vecs.push_back('{LB,  32'h101, 0, 32'h80FF1234, 1, 0, 4'b0010, 32'h100, 0, 1, 32'h00000012});
    vecs.push_back('{LH,  32'h102, 0, 32'h80FF1234, 0, 0, 4'b1100, 32'h100, 0, 1, 32'hFFFF80FF});
    vecs.push_back('{LHU, 32'h100, 0, 32'h80FF9234, 2, 0, 4'b0011, 32'h100, 0, 1, 32'h00009234});
    vecs.push_back('{LW,  32'h204, 0, 32'hCAFEF00D, 1, 0, 4'b1111, 32'h204, 0, 1, 32'hCAFEF00D});
    vecs.push_back('{SB,  32'h301, 32'h000000A5, 0, 0, 1, 4'b0010, 32'h300, 32'hA5A5A5A5, 0, 0});
    vecs.push_back('{SH,  32'h202, 32'hDEADBEEF, 0, 3, 1, 4'b1100, 32'h200, 32'hBEEFBEEF, 0, 0});
    vecs.push_back('{SW,  32'h400, 32'h12345678, 0, 0, 1, 4'b1111, 32'h400, 32'h12345678, 0, 0});
    repeat (2) @(posedge clk);
    @(negedge clk) chk("reset_state", {bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err, stallreq}, 0);
    @(posedge clk); #1 rst = 0;
    foreach (vecs[i]) run_vec(vecs[i]);
    // non-memory pass-through
    drive(NOP, 32'h6, 0); mem_wdata = 32'h12345678; mem_wd = 5'd5; mem_wreg = 1;
    #1 chk("nonmem_wb", {wb_wd, wb_wreg, wb_wdata, stallreq}, {5'd5, 1'b1, 32'h12345678, 1'b0});
    // misaligned word load / store, and misaligned half load
    drive(LW, 32'h6, 0);
    #1 chk("lw_adel", {excp_adel, excp_ades, bad_vaddr, wb_wreg, stallreq}, {2'b10, 32'h6, 2'b00});
    @(negedge clk) chk("lw_adel_nobus", bus_req, 0);
    drive(SW, 32'h6, 0);
    #1 chk("sw_ades", {excp_adel, excp_ades, bad_vaddr, wb_wreg, stallreq}, {2'b01, 32'h6, 2'b00});
    @(negedge clk) chk("sw_ades_nobus", bus_req, 0);
    drive(LH, 32'h11, 0);
    #1 chk("lh_adel", {excp_adel, bad_vaddr, stallreq}, {1'b1, 32'h11, 1'b0});
    @(negedge clk) chk("lh_adel_nobus", bus_req, 0);
    // flushed instruction in IDLE starts nothing
    drive(LW, 32'h40, 0); flush = 1;
    #1 chk("idle_flush", {stallreq, wb_wreg}, 2'b00);
    @(negedge clk) chk("idle_flush_nobus", bus_req, 0);
    // watchdog: no ack, TIMEOUT_CYCLES=4
    drive(LW, 32'h40, 0); flush = 0; mem_wreg = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!bus_req) break;
      n++;
    end
    chk("timeout_req_cycles", n, 4);
    chk("timeout_done", {bus_err, wb_wreg, stallreq}, 3'b100);
    drive(NOP, 0, 0); mem_wreg = 0;
    @(negedge clk) chk("timeout_pulse_end", {bus_err, bus_req, stallreq}, 3'b000);
    // flush in 2nd BUS cycle, ack in 4th
    drive(LW, 32'h80, 0); mem_wreg = 1; mem_wdata = 32'h0BADF00D; bus_rdata = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 flush = (i == 1); bus_ack = (i == 3);
      @(negedge clk) chk("flush_stall_held", {bus_req, stallreq}, 2'b11);
    end
    @(posedge clk); #1 bus_ack = 0; mem_aluop = NOP;
    @(negedge clk) chk("flush_to_idle", {stallreq, bus_req, wb_wreg, wb_wdata}, {3'b001, 32'h0BADF00D});
    // reset mid-BUS
    drive(LW, 32'h90, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) chk("pre_rst_bus", bus_req, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0; mem_aluop = NOP;
    @(negedge clk) chk("rst_mid_bus", {bus_req, stallreq, bus_be}, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
